// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//
// Turns one-cycle key-press pulses into an ordered stream of key codes. Each
// press marks its key pending. A round-robin arbiter moves one pending key per
// cycle into a small FIFO, and the consumer drains the FIFO through a
// valid/ready handshake. A press that arrives while its key is still pending,
// and that is not being granted in the same cycle, is counted as dropped.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_press  one-cycle press pulses, one bit per key
//   evt_valid  FIFO head holds a valid key code
//   evt_code   key index at the FIFO head (registered)
//   evt_ready  consumer accepts the head this cycle
//   level      FIFO occupancy, 0..DEPTH
//   ovf        sticky flag, at least one press was dropped
//   drop_cnt   dropped press count, saturates at 255
//   ovf_clr    synchronous clear of ovf and drop_cnt
module key_event_arbiter #(
    parameter int unsigned NKEYS  = 4,
    parameter int unsigned CODE_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NKEYS-1:0]  key_press,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    input  logic              evt_ready,
    output logic [PTR_W:0]    level,
    output logic              ovf,
    output logic [7:0]        drop_cnt,
    input  logic              ovf_clr
);

    localparam logic [PTR_W:0]    LevelFull = (PTR_W + 1)'(DEPTH);
    localparam logic [CODE_W-1:0] LastInit  = CODE_W'(NKEYS - 1);

    logic [NKEYS-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] head_q, head_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [CODE_W-1:0] mem_q [DEPTH];

    logic              grant_valid;
    logic [CODE_W-1:0] grant_idx;
    logic [CODE_W-1:0] idx;
    logic [NKEYS-1:0]  grant_vec;
    logic [NKEYS-1:0]  drop_vec;
    logic [4:0]        drop_n;
    logic [7:0]        drop_base;
    logic [8:0]        drop_sum;
    logic              push, pop;

    // Round-robin search starting just after the last granted key, ending on
    // the last granted key itself. The full check uses the registered level
    // only, so a pop this cycle never makes room for a push this cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        if (level_q != LevelFull) begin
            for (int unsigned off = 1; off <= NKEYS; off++) begin
                idx = CODE_W'((32'(last_q) + off) % NKEYS);
                if (!grant_valid && pend_q[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A press on the key being granted is a new event, so set beats clear.
    assign pend_d   = (pend_q & ~grant_vec) | key_press;
    assign drop_vec = key_press & pend_q & ~grant_vec;
    assign last_d   = grant_valid ? grant_idx : last_q;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < int'(NKEYS); i++) begin
            drop_n = drop_n + 5'(drop_vec[i]);
        end
    end

    // Drops in the clearing cycle survive the clear.
    assign drop_base  = ovf_clr ? 8'd0 : drop_cnt_q;
    assign drop_sum   = {1'b0, drop_base} + 9'(drop_n);
    assign drop_cnt_d = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
    assign ovf_d      = (ovf_clr ? 1'b0 : ovf_q) | (drop_n != 5'd0);

    assign push = grant_valid;
    assign pop  = valid_q && evt_ready;

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // The head is held in its own register so evt_code is glitch-free. When
    // the slot being written this cycle becomes the new head, take the write
    // data directly since mem_q has not been updated yet.
    always_comb begin
        valid_d = (level_d != '0);
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = grant_idx;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            last_q     <= LastInit;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
            end
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = head_q;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_press;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic [2:0] level;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    key_event_arbiter #(
        .NKEYS  (4),
        .CODE_W (2),
        .DEPTH  (4),
        .PTR_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_press (key_press),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .level     (level),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        key_press = mask;
        step();
        key_press = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Wait at most max_wait cycles for an event, check its code, then move on
    // one cycle (which pops it when evt_ready is high).
    task automatic wait_evt(input string tag, input int code, input int max_wait);
        int n = 0;
        while (!evt_valid && n < max_wait) begin
            step();
            n++;
        end
        check({tag, " valid"}, evt_valid, 1);
        check({tag, " code"}, evt_code, code);
        step();
    endtask

    initial begin
        bit seen;
        rst       = 1'b0;
        key_press = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2 rst = 1'b1;
        #2;
        check("rst valid", evt_valid, 0);
        check("rst code", evt_code, 0);
        check("rst level", level, 0);
        check("rst ovf", ovf, 0);
        check("rst drop", drop_cnt, 0);
        step();
        rst = 1'b0;

        // Single press: event two cycles later, exactly one cycle long.
        evt_ready = 1'b1;
        press(4'b0100);
        check("t1 early valid", evt_valid, 0);
        step();
        wait_evt("t1 evt", 2, 0);
        check("t1 after valid", evt_valid, 0);
        check("t1 after level", level, 0);

        // All keys at once: codes 0..3 back to back.
        do_reset();
        press(4'b1111);
        step();
        wait_evt("t2 e0", 0, 0);
        wait_evt("t2 e1", 1, 0);
        wait_evt("t2 e2", 2, 0);
        wait_evt("t2 e3", 3, 0);
        check("t2 end valid", evt_valid, 0);
        check("t2 ovf", ovf, 0);

        // Round robin: after key 1 is granted, key 3 beats key 0.
        do_reset();
        press(4'b0010);
        press(4'b1001);
        wait_evt("t3 e1", 1, 3);
        wait_evt("t3 e3", 3, 0);
        wait_evt("t3 e0", 0, 0);

        // Backpressure: fill with 0,1,2,3 then drop four key-0 presses.
        do_reset();
        evt_ready = 1'b0;
        press(4'b0001);
        step();
        press(4'b0010);
        step();
        press(4'b0100);
        step();
        press(4'b1000);
        step();
        check("t4 full level", level, 4);
        check("t4 head valid", evt_valid, 1);
        check("t4 head code", evt_code, 0);
        check("t4 no drop yet", drop_cnt, 0);
        press(4'b0001);
        for (int i = 0; i < 4; i++) begin
            step();
            press(4'b0001);
        end
        check("t4 drop", drop_cnt, 4);
        check("t4 ovf", ovf, 1);
        check("t4 level held", level, 4);
        evt_ready = 1'b1;
        wait_evt("t4 d0", 0, 0);
        wait_evt("t4 d1", 1, 0);
        wait_evt("t4 d2", 2, 0);
        wait_evt("t4 d3", 3, 0);
        wait_evt("t4 d4", 0, 0);
        check("t4 drained valid", evt_valid, 0);
        check("t4 drained level", level, 0);

        // Press coincident with grant of the same key: two events, no drop.
        press(4'b0100);
        press(4'b0100);
        wait_evt("t5 e0", 2, 0);
        wait_evt("t5 e1", 2, 0);
        check("t5 drop kept", drop_cnt, 4);
        check("t5 ovf kept", ovf, 1);
        check("t5 end valid", evt_valid, 0);

        // Saturation: key 0 every cycle into a stalled FIFO. First 5 presses
        // fill the queue and the pending bit; each one after that drops.
        evt_ready = 1'b0;
        for (int i = 0; i < 255; i++) begin
            press(4'b0001);
        end
        check("sat 254", drop_cnt, 254);
        check("sat level", level, 4);
        press(4'b0001);
        check("sat 255", drop_cnt, 255);
        press(4'b0001);
        check("sat hold", drop_cnt, 255);
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("sat drained", level, 0);

        // Reset mid-operation with level 3 and key 3 still pending.
        evt_ready = 1'b0;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        check("t6 pre level", level, 3);
        rst = 1'b1;
        #1;
        check("t6 valid", evt_valid, 0);
        check("t6 code", evt_code, 0);
        check("t6 level", level, 0);
        check("t6 ovf", ovf, 0);
        check("t6 drop", drop_cnt, 0);
        step();
        rst = 1'b0;
        evt_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | evt_valid;
        end
        check("t6 no events", seen, 0);

        // Two drops in one cycle, then a drop coincident with ovf_clr.
        press(4'b0111);
        key_press = 4'b0110;
        step();
        check("t7 two drops", drop_cnt, 2);
        check("t7 ovf set", ovf, 1);
        key_press = 4'b0100;
        ovf_clr   = 1'b1;
        step();
        key_press = '0;
        ovf_clr   = 1'b0;
        check("t7 clr+drop cnt", drop_cnt, 1);
        check("t7 clr+drop ovf", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t7 clr cnt", drop_cnt, 0);
        check("t7 clr ovf", ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Collects single-cycle key-press pulses from NKEYS debounced key inputs and serialises them into an ordered event stream. Each debouncer's one-clock press pulse sets a pending bit. A round-robin arbiter grants one pending key per cycle into a small FIFO. Downstream consumers (the SPI slave register file, LED/UI logic) read key codes through a valid/ready handshake, and the block reports any presses it loses.

## Interface
Parameters:
- NKEYS, 4, number of key inputs (2..16)
- CODE_W, 2, key code width; must equal ceil(log2(NKEYS))
- DEPTH, 4, FIFO depth; power of two, at least 2
- PTR_W, 2, log2(DEPTH)

Ports:
- clk, input, 1, system clock; all logic on rising edge
- rst, input, 1, asynchronous, active-high reset
- key_press, input, NKEYS, one-cycle press pulses, one bit per debouncer, synchronous to clk
- evt_valid, output, 1, FIFO head holds a valid key code
- evt_code, output, CODE_W, key index at the FIFO head
- evt_ready, input, 1, consumer accepts the head this cycle
- level, output, PTR_W+1, current FIFO occupancy (0..DEPTH)
- ovf, output, 1, sticky flag: at least one press was dropped
- drop_cnt, output, 8, count of dropped presses; saturates at 255
- ovf_clr, input, 1, synchronous clear of ovf and drop_cnt

## Operation
- Pending register pend[NKEYS-1:0]:
  - pend[i] is set by key_press[i] and cleared when key i is granted.
  - If a press and a grant of the same key occur in the same cycle, set wins and pend[i] stays 1 (this is a new event).
- Drop rule:
  - A press is dropped when key_press[i]=1, pend[i]=1 and key i is not granted that cycle.
  - Each dropped key adds one to drop_cnt (several drops in one cycle add their total, saturating at 255) and sets ovf.
- Arbitration:
  - Combinational, over pend, using round-robin pointer last (CODE_W bits).
  - Search order: last+1, last+2, … (modulo NKEYS), wrapping to last itself.
  - A grant is made only when pend≠0 and level<DEPTH.
  - The grant pushes the key index into the FIFO and loads last with that index.
- FIFO:
  - DEPTH entries of CODE_W bits, with read/write pointers of PTR_W bits that wrap naturally.
  - Pop when evt_valid && evt_ready.
  - The full check uses the registered level only; a pop in the same cycle does not free space for a push (no bypass).
  - Push and pop in the same cycle: level is unchanged and both pointers advance.
- evt_code is the registered head entry; its value is don't-care when evt_valid=0 but must not glitch while evt_valid=1.
- evt_ready while evt_valid=0 has no effect.
- ovf_clr: ovf and drop_cnt clear to 0. A drop in the same cycle as ovf_clr wins: ovf=1, drop_cnt=number dropped that cycle.

## Timing
- Reset values (asynchronous):
  - pend=0, last=NKEYS-1 (key 0 has first priority), pointers=0, level=0
  - evt_valid=0, evt_code=0, ovf=0, drop_cnt=0
- Latency, with key_press[i] high during cycle c and an empty, idle FIFO:
  - pend[i]=1 after edge c
  - grant and push at edge c+1
  - evt_valid=1 with evt_code=i during cycle c+2
- Throughput: one grant per cycle and one pop per cycle; the FIFO sustains full rate with evt_ready held high.
- level, ovf and drop_cnt are registered and update on the edge following the event.
- Reset mid-operation clears all queued and pending events immediately; no event is emitted after reset deassertion until a new press arrives.

## Test plan
- Single press: key_press=4'b0100 for one cycle, evt_ready=1. Expect evt_valid high for exactly one cycle, two cycles later, with evt_code=2; afterwards level returns to 0.
- Simultaneous presses: key_press=4'b1111 for one cycle after reset, evt_ready=1. Expect codes 0,1,2,3 on consecutive cycles, ovf=0.
- Round-robin fairness: grant key 1 first, then press keys 0 and 3 together. Expect code 3 before code 0.
- Backpressure and drop: evt_ready=0, pulse key 0 six times and keys 1..3 once each (at least 2 cycles apart). Then:
  - level saturates at 4 with queue 0,1,2,3.
  - Extra key-0 presses while pend[0]=1 are dropped: ovf=1 and drop_cnt equals the drops.
  - After evt_ready=1, all queued codes drain in order.
- Press coincident with grant: key 2 pending and granted in the same cycle a new key_press[2] arrives. Expect two code-2 events and drop_cnt unchanged.
- Reset mid-operation: with level=3 and pend≠0, assert rst for one cycle. Expect all outputs at their reset values at once and no events afterwards; then ovf_clr asserted together with a drop yields ovf=1, drop_cnt=1.
